// File: rtl/map_loader.sv
// Map loader: streams one 9x9 puzzle map from a packed map vector as
// cell words over a valid/ready handshake, optionally revealing the solution.
module map_loader #(
    parameter int unsigned NUM_MAPS = 15,
    parameter int unsigned CELLS    = 81,
    parameter int unsigned CELL_W   = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MAPS*CELLS*CELL_W-1:0] maps,
    input  logic                             start,
    input  logic [3:0]                       map_sel,
    input  logic                             reveal,
    output logic                             cell_valid,
    input  logic                             cell_ready,
    output logic [6:0]                       cell_addr,
    output logic [3:0]                       cell_digit,
    output logic                             cell_given,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int unsigned MAP_W   = CELLS * CELL_W;
    localparam int unsigned TOTAL_W = NUM_MAPS * MAP_W;
    localparam int unsigned IDX_W   = $clog2(TOTAL_W);
    localparam int unsigned LAST    = CELLS - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_n;
    logic [6:0]         cnt, cnt_n;
    logic [3:0]         sel, sel_n;
    logic               rev, rev_n;

    logic [IDX_W-1:0]   base;
    logic [CELL_W-1:0]  word;

    logic               valid_n;
    logic [6:0]         addr_n;
    logic [3:0]         digit_n;
    logic               given_n;
    logic               busy_n;
    logic               done_n;
    logic               error_n;

    // Next-state, capture and counter logic; outputs are precomputed for the
    // next cycle so they can be registered and still appear one cycle after start.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        rev_n   = rev;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (32'(map_sel) < NUM_MAPS) begin
                        sel_n   = map_sel;
                        rev_n   = reveal;
                        cnt_n   = '0;
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_LOAD: begin
                if (cell_ready) begin
                    if (cnt == 7'(LAST)) begin
                        state_n = S_DONE;
                    end else begin
                        cnt_n = cnt + 7'd1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Select the cell word for the upcoming cycle (map 0 and cell 0 are most significant).
    always_comb begin
        base = IDX_W'((NUM_MAPS - 1 - 32'(sel_n)) * MAP_W + (LAST - 32'(cnt_n)) * CELL_W);
        word = maps[base +: CELL_W];
    end

    // Output values for the upcoming cycle; everything is zero outside LOAD.
    always_comb begin
        valid_n = 1'b0;
        addr_n  = '0;
        digit_n = '0;
        given_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = (state_n == S_DONE);
        error_n = (state_n == S_ERR);
        if (state_n == S_LOAD) begin
            valid_n = 1'b1;
            busy_n  = 1'b1;
            addr_n  = cnt_n;
            given_n = word[CELL_W-1];
            digit_n = (word[CELL_W-1] || rev_n) ? 4'(word[CELL_W-2:0]) : 4'd0;
        end
    end

    // State, capture and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= '0;
            rev        <= 1'b0;
            cell_valid <= 1'b0;
            cell_addr  <= '0;
            cell_digit <= '0;
            cell_given <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            rev        <= rev_n;
            cell_valid <= valid_n;
            cell_addr  <= addr_n;
            cell_digit <= digit_n;
            cell_given <= given_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
        end
    end

endmodule

// File: tb/tb_map_loader.sv
// Testbench for map_loader: table of load requests plus directed corner sequences.
module tb_map_loader;

    localparam int NM = 15;
    localparam int NC = 81;

    logic           clk = 1'b0;
    logic           reset;
    logic [6074:0]  maps;
    logic           start;
    logic [3:0]     map_sel;
    logic           reveal;
    logic           cell_valid;
    logic           cell_ready;
    logic [6:0]     cell_addr;
    logic [3:0]     cell_digit;
    logic           cell_given;
    logic           busy;
    logic           done;
    logic           error;

    int tests = 0;
    int fails = 0;

    logic [4:0] mapv [NM][NC];

    typedef struct {
        logic [3:0] sel;
        logic       rev;
        bit         rnd;
        bit         inject;
        bit         exp_err;
    } vec_t;

    vec_t tbl [8];

    map_loader dut (
        .clk        (clk),
        .reset      (reset),
        .maps       (maps),
        .start      (start),
        .map_sel    (map_sel),
        .reveal     (reveal),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_addr  (cell_addr),
        .cell_digit (cell_digit),
        .cell_given (cell_given),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_digit(input int k, input int c, input logic rev);
        logic [4:0] w;
        w = mapv[k][c];
        return (w[4] || rev) ? int'(w[3:0]) : 0;
    endfunction

    task automatic chk_idle_outputs(input string name);
        chk({name, " valid"}, int'(cell_valid), 0);
        chk({name, " addr"},  int'(cell_addr),  0);
        chk({name, " digit"}, int'(cell_digit), 0);
        chk({name, " given"}, int'(cell_given), 0);
        chk({name, " busy"},  int'(busy),       0);
        chk({name, " done"},  int'(done),       0);
        chk({name, " error"}, int'(error),      0);
    endtask

    // Full load: every streamed word checked against the map model.
    task automatic run_load(input logic [3:0] sel, input logic rev, input bit rnd, input bit inject);
        int idx;
        int cyc;
        bit got_done;
        idx = 0;
        cyc = 0;
        got_done = 0;
        start = 1'b1; map_sel = sel; reveal = rev; cell_ready = 1'b1;
        step();
        start = 1'b0; map_sel = ~sel; reveal = ~rev;
        cyc = 1;
        while (!got_done && cyc < 600) begin
            if (done) begin
                got_done = 1;
                chk("transfer count", idx, NC);
                if (!rnd) chk("done latency", cyc, 82);
                chk("done valid low", int'(cell_valid), 0);
                chk("done busy low", int'(busy), 0);
            end else begin
                if (cell_valid !== 1'b1 || cell_addr != 7'(idx) ||
                    int'(cell_digit) != exp_digit(int'(sel), idx, rev) ||
                    cell_given != mapv[sel][idx][4] || busy !== 1'b1) begin
                    chk("stream valid", int'(cell_valid), 1);
                    chk("stream addr", int'(cell_addr), idx);
                    chk("stream digit", int'(cell_digit), exp_digit(int'(sel), idx, rev));
                    chk("stream given", int'(cell_given), int'(mapv[sel][idx][4]));
                end
                cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (inject) begin
                    start = 1'b1;
                    map_sel = 4'((int'(sel) + 3) % NM);
                end
                step();
                if (cell_ready) idx++;
                cyc++;
            end
        end
        if (!got_done) chk("done timeout", 0, 1);
        tests++;
        // Start presented in the DONE cycle must be ignored.
        start = 1'b1; map_sel = 4'd2; cell_ready = 1'b1;
        step();
        start = 1'b0;
        chk("post-done done low", int'(done), 0);
        chk("start in DONE ignored", int'(busy), 0);
        chk("post-done valid", int'(cell_valid), 0);
    endtask

    initial begin
        for (int k = 0; k < NM; k++) begin
            for (int c = 0; c < NC; c++) begin
                mapv[k][c] = {1'(((k + c) % 3) == 1), 4'((k * 7 + c * 5 + 3) % 16)};
            end
        end
        mapv[0][0] = {1'b0, 4'd1};
        mapv[0][1] = {1'b1, 4'd9};
        mapv[0][2] = {1'b0, 4'd6};
        maps = '0;
        for (int k = 0; k < NM; k++) begin
            for (int c = 0; c < NC; c++) begin
                maps[(NM - k) * 405 - 1 - c * 5 -: 5] = mapv[k][c];
            end
        end

        tbl[0] = '{sel: 4'd0,  rev: 1'b1, rnd: 0, inject: 0, exp_err: 0};
        tbl[1] = '{sel: 4'd0,  rev: 1'b0, rnd: 0, inject: 0, exp_err: 0};
        tbl[2] = '{sel: 4'd7,  rev: 1'b1, rnd: 0, inject: 0, exp_err: 0};
        tbl[3] = '{sel: 4'd14, rev: 1'b0, rnd: 0, inject: 0, exp_err: 0};
        tbl[4] = '{sel: 4'd15, rev: 1'b1, rnd: 0, inject: 0, exp_err: 1};
        tbl[5] = '{sel: 4'd9,  rev: 1'b1, rnd: 1, inject: 0, exp_err: 0};
        tbl[6] = '{sel: 4'd5,  rev: 1'b0, rnd: 0, inject: 1, exp_err: 0};
        tbl[7] = '{sel: 4'd12, rev: 1'b1, rnd: 1, inject: 1, exp_err: 0};

        reset = 1'b1; start = 1'b1; map_sel = 4'd3; reveal = 1'b1; cell_ready = 1'b1;
        step();
        step();
        chk_idle_outputs("reset");
        reset = 1'b0; start = 1'b0;
        step();

        // Table of load requests.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].exp_err) begin
                start = 1'b1; map_sel = tbl[i].sel; reveal = tbl[i].rev;
                step();
                start = 1'b0;
                chk("error pulse", int'(error), 1);
                chk("error valid low", int'(cell_valid), 0);
                chk("error busy low", int'(busy), 0);
                step();
                chk("error one cycle", int'(error), 0);
                chk("error no valid", int'(cell_valid), 0);
            end else begin
                run_load(tbl[i].sel, tbl[i].rev, tbl[i].rnd, tbl[i].inject);
            end
            step();
        end

        // Map 0 first cells with the solution revealed.
        start = 1'b1; map_sel = 4'd0; reveal = 1'b1; cell_ready = 1'b1;
        step();
        start = 1'b0;
        chk("m0r1 c0 digit", int'(cell_digit), 1);
        chk("m0r1 c0 given", int'(cell_given), 0);
        step();
        chk("m0r1 c1 digit", int'(cell_digit), 9);
        chk("m0r1 c1 given", int'(cell_given), 1);
        step();
        chk("m0r1 c2 addr", int'(cell_addr), 2);
        chk("m0r1 c2 digit", int'(cell_digit), 6);
        chk("m0r1 c2 given", int'(cell_given), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Map 0 puzzle-only: non-given cell reads as empty.
        start = 1'b1; map_sel = 4'd0; reveal = 1'b0;
        step();
        start = 1'b0;
        chk("m0r0 c0 digit", int'(cell_digit), 0);
        chk("m0r0 c0 given", int'(cell_given), 0);
        step();
        chk("m0r0 c1 digit", int'(cell_digit), 9);
        chk("m0r0 c1 given", int'(cell_given), 1);

        // Reset in the middle of a load, then restart immediately with map 14.
        begin
            int guard;
            guard = 0;
            while (cell_addr != 7'd40 && guard < 100) begin
                step();
                guard++;
            end
            chk("reached addr 40", int'(cell_addr), 40);
        end
        reset = 1'b1;
        step();
        chk_idle_outputs("mid-load reset");
        reset = 1'b0;
        run_load(4'd14, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/map_loader.md
MAP_LOADER -- requirements
Module: map_loader

Interface
REQ-001 Parameter NUM_MAPS, 15, number of puzzle maps in the packed map vector.
REQ-002 Parameter CELLS, 81, cells per map (9x9 board, row-major).
REQ-003 Parameter CELL_W, 5, bits per cell: {given flag, 4-bit digit 1..9}.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 maps  input  NUM_MAPS*CELLS*CELL_W (6075)  packed puzzle maps, static during operation.
REQ-007 start  input  1  one-cycle request to load a map; sampled only in IDLE.
REQ-008 map_sel  input  4  index of map to load, captured with start.
REQ-009 reveal  input  1  captured with start; 1 = stream full solution, 0 = puzzle only.
REQ-010 cell_valid  output  1  streamed cell word is valid.
REQ-011 cell_ready  input  1  downstream board accepts a cell word.
REQ-012 cell_addr  output  7  cell index 0..80.
REQ-013 cell_digit  output  4  digit to write (0 = empty cell).
REQ-014 cell_given  output  1  cell is a fixed clue.
REQ-015 busy  output  1  high while in LOAD.
REQ-016 done  output  1  one-cycle pulse after the last cell transfer.
REQ-017 error  output  1  one-cycle pulse when start carries map_sel >= NUM_MAPS.

Function
REQ-018 Map k shall occupy maps[(NUM_MAPS-k)*405-1 -: 405]; map 0 is the most significant 405 bits.
REQ-019 Cell c of a map shall occupy the 5 bits at offset (CELLS-1-c)*5 from the map LSB (cell 0 most significant); bit 4 = given, bits 3:0 = digit.
REQ-020 States: IDLE, LOAD, DONE, ERR; encoding at implementer's discretion.
REQ-021 IDLE: start=1 with map_sel < NUM_MAPS -> capture map_sel and reveal, clear cell counter to 0, go to LOAD next cycle.
REQ-022 IDLE: start=1 with map_sel >= NUM_MAPS -> go to ERR; ERR asserts error for exactly one cycle, then returns to IDLE.
REQ-023 LOAD: cell_valid=1; cell_addr = counter; cell_given = cell bit 4; cell_digit = digit if given or captured reveal=1, else 0.
REQ-024 A transfer occurs on a cycle with cell_valid=1 and cell_ready=1; counter then increments by 1.
REQ-025 While cell_ready=0, cell_addr, cell_digit, cell_given shall hold stable and cell_valid stays 1.
REQ-026 Transfer with counter = CELLS-1 -> go to DONE; counter never exceeds 80.
REQ-027 DONE: done=1 for exactly one cycle, cell_valid=0, then IDLE.
REQ-028 start, map_sel, reveal are ignored outside IDLE; a start in the DONE cycle is ignored.
REQ-029 First cell_valid shall appear the cycle after the accepted start; with cell_ready held high, done pulses 82 cycles after start (81 transfers + 1).
REQ-030 Outside LOAD: cell_valid=0, cell_addr=0, cell_digit=0, cell_given=0.
REQ-031 Cell words with digit 0 or >9 shall be streamed unchanged (no checking).

Reset
REQ-032 reset=1 at a clock edge shall force IDLE, counter=0, captured map_sel=0, reveal=0 and all outputs to 0, overriding any other input, including mid-LOAD.
REQ-033 After reset deasserts, the block shall accept start on the first cycle.

Verification
REQ-034 start, map_sel=0, reveal=1, cell_ready=1 -> cell 0 = {given=0, digit=1}, cell 1 = {given=1, digit=9}, cell 2 = {0,6}; addr 0..80 in order; done 82 cycles after start.
REQ-035 map_sel=0, reveal=0 -> cell 0 digit=0 given=0; cell 1 digit=9 given=1.
REQ-036 cell_ready toggled pseudo-randomly -> exactly 81 transfers, outputs stable whenever valid=1 and ready=0, no address skipped or repeated.
REQ-037 start with map_sel=15 -> error pulse one cycle, cell_valid never asserted, back to IDLE.
REQ-038 reset asserted at addr 40 of a load -> all outputs 0 next cycle; new start with map_sel=14 streams the last 405 bits of maps from addr 0.
REQ-039 start pulses during LOAD and DONE -> ignored; load completes with original map_sel.
